pid_controller: RTL and testbench
=================================

Name: pid_controller

Overview:
- Single-channel discrete PID regulator with a fixed setpoint.
- On each `pid_start` pulse it samples a 16-bit unsigned measurement and computes error, integral and derivative terms with a multi-cycle FSM.
- Publishes a saturated 16-bit unsigned control word.
- Sits between a sensor/ADC front end and an actuator/PWM stage.

Parameters:
- SETPOINT, 54321: target value; error = SETPOINT − data_in.
- KP, 16: proportional gain, unsigned, fixed point with FRAC fractional bits.
- KI, 2: integral gain, same format.
- KD, 8: derivative gain, same format.
- FRAC, 4: fractional bits of the gains; the sum is arithmetically right-shifted by FRAC.
- OUT_BIAS, 32768: offset added to the scaled sum; this is the output for zero control effort.
- INT_LIMIT, 1048576: magnitude limit for the integral accumulator.

Ports:
- clk  in  1  system clock; all logic is on the rising edge.
- rst  in  1  synchronous, active-high reset.
- pid_start  in  1  start request, sampled on the rising edge.
- data_in  in  16  unsigned measurement, sampled in the cycle pid_start is seen.
- data_out  out  16  unsigned control word, registered.
- pid_done  out  1  one-cycle pulse when data_out updates.

Behaviour:
- Reset (synchronous, rst=1 at the edge) clears the following and wins over everything, including an operation in flight:
  - data_out=OUT_BIAS, pid_done=0.
  - integral=0, prev_err=0.
  - FSM returns to IDLE.
- FSM sequence: IDLE → ERR → MUL → SUM → OUT → IDLE.
  - IDLE: if pid_start=1, capture data_in and go to ERR. pid_start is ignored in every other state; no queuing.
  - ERR: e = SETPOINT − data_in, 17-bit signed. d = e − prev_err, 18-bit signed. integral += e. prev_err ← e.
  - MUL: pP = KP·e, pI = KI·integral, pD = KD·d. Use signed 40-bit products with gains zero-extended.
  - SUM: s = pP + pI + pD in 40 bits. u = s >>> FRAC, arithmetic shift, rounds toward −∞.
  - OUT: y = OUT_BIAS + u. data_out = clamp(y, 0, 65535). pid_done=1 for this single cycle.
- The integral update in ERR happens before use, so the new error contributes in the same run.
- Latency: pid_start high at edge N → data_out valid and pid_done high after edge N+4. Minimum start-to-start spacing is 5 cycles.
- A pid_start held high for several cycles triggers once, plus again after returning to IDLE if still high.
- data_out holds its value between runs.
- Simultaneous rst and pid_start: reset wins and the start is dropped.

Optional Feature:
- Macro PID_INT_CLAMP_EN.
- When defined, integral saturates to [−INT_LIMIT, +INT_LIMIT] after each update (anti-windup).
- When undefined, integral is a free-running 32-bit signed accumulator that wraps modulo 2^32.
- The directed values below are identical either way.

Decomposition:
- pid_pkg holds:
  - width constants: ERR_W=17, DER_W=18, INT_W=32, ACC_W=40.
  - the FSM state enum: IDLE, ERR, MUL, SUM, OUT.
  - a sign-aware clamp function.
- One sub-module, pid_sat: generic signed-to-unsigned saturator, used for the output clamp and, when the feature is enabled, the integral clamp.

Test Plan:
- Reset: pulse rst → data_out=32768, pid_done=0; pid_start held low → no change.
- Zero error: data_in=54321, one-cycle pid_start → after 4 cycles data_out=32768, pid_done pulses once, integral stays 0.
- Negative error, following the previous run: data_in=55000 → e=−679, I=−679, d=−679, s=−17654, u=−1104, data_out=31664.
- Positive error, following the previous run: data_in=51000 → e=3321, I=2642, d=4000, s=90420, u=5651, data_out=38419.
- Saturation: repeated data_in=0 → data_out climbs, then holds at 65535. With PID_INT_CLAMP_EN the integral stops at 1048576.
- Busy and reset abort:
  - pid_start re-asserted during MUL → ignored.
  - rst during SUM → data_out=32768, no pid_done, next run behaves as from reset.

Source files
------------

// File: rtl/pid_pkg.sv
// Shared widths, FSM state type and clamp helper for the PID regulator.
package pid_pkg;

  localparam int ERR_W = 17;
  localparam int DER_W = 18;
  localparam int INT_W = 32;
  localparam int ACC_W = 40;

  typedef enum logic [2:0] {
    IDLE,
    ERR,
    MUL,
    SUM,
    OUT
  } pid_state_e;

  // Limits a signed value to the inclusive range [lo, hi].
  function automatic logic signed [ACC_W-1:0] clampSigned(
    input logic signed [ACC_W-1:0] value,
    input logic signed [ACC_W-1:0] lo,
    input logic signed [ACC_W-1:0] hi
  );
    logic signed [ACC_W-1:0] result;
    result = value;
    if (value < lo) begin
      result = lo;
    end else if (value > hi) begin
      result = hi;
    end
    return result;
  endfunction

endpackage

// File: rtl/pid_sat.sv
// Generic saturator: clamps a wide signed value into [LO, HI] and returns
// the low OUT_W bits (an unsigned word for LO >= 0, two's complement otherwise).
module pid_sat
  import pid_pkg::*;
#(
  parameter int     OUT_W = 16,
  parameter longint LO    = 0,
  parameter longint HI    = 65535
) (
  input  logic signed [ACC_W-1:0] value_i,
  output logic        [OUT_W-1:0] value_o
);

  localparam logic signed [ACC_W-1:0] LoV = ACC_W'(LO);
  localparam logic signed [ACC_W-1:0] HiV = ACC_W'(HI);

  // Clamp first, then narrow; the bounds guarantee the kept bits are exact.
  always_comb begin
    value_o = OUT_W'(clampSigned(value_i, LoV, HiV));
  end

endmodule

// File: rtl/pid_controller.sv
// Single-channel PID regulator with a fixed setpoint and a 5-state FSM
// (IDLE -> ERR -> MUL -> SUM -> OUT). Optional anti-windup of the integral
// accumulator is enabled by defining PID_INT_CLAMP_EN; otherwise the integral
// wraps as a 32-bit signed accumulator.
module pid_controller
  import pid_pkg::*;
#(
  parameter int SETPOINT  = 54321,
  parameter int KP        = 16,
  parameter int KI        = 2,
  parameter int KD        = 8,
  parameter int FRAC      = 4,
  parameter int OUT_BIAS  = 32768
`ifdef PID_INT_CLAMP_EN
  ,
  parameter int INT_LIMIT = 1048576
`endif
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        pid_start,
  input  logic [15:0] data_in,
  output logic [15:0] data_out,
  output logic        pid_done
);

  localparam logic signed [ERR_W-1:0] SetpointS = ERR_W'(SETPOINT);
  localparam logic signed [ACC_W-1:0] KpS       = ACC_W'(KP);
  localparam logic signed [ACC_W-1:0] KiS       = ACC_W'(KI);
  localparam logic signed [ACC_W-1:0] KdS       = ACC_W'(KD);
  localparam logic signed [ACC_W-1:0] BiasS     = ACC_W'(OUT_BIAS);

  pid_state_e              state_q;
  logic        [15:0]      meas_q;
  logic signed [ERR_W-1:0] err_q, prev_err_q, err_d;
  logic signed [DER_W-1:0] der_q, der_d;
  logic signed [INT_W-1:0] integ_q, integ_d;
  logic signed [ACC_W-1:0] p_q, i_q, d_q, p_d, i_d, d_d;
  logic signed [ACC_W-1:0] u_q, sum_d, u_d, y_d;
  logic        [15:0]      data_out_q, out_d;
  logic                    done_q;

  // Datapath for every stage, computed from the registered stage inputs.
  always_comb begin
    err_d = SetpointS - $signed({1'b0, meas_q});
    der_d = {err_d[ERR_W-1], err_d} - {prev_err_q[ERR_W-1], prev_err_q};
    p_d   = KpS * ACC_W'(err_q);
    i_d   = KiS * ACC_W'(integ_q);
    d_d   = KdS * ACC_W'(der_q);
    sum_d = p_q + i_q + d_q;
    u_d   = sum_d >>> FRAC;
    y_d   = BiasS + u_q;
  end

`ifdef PID_INT_CLAMP_EN
  logic signed [ACC_W-1:0] integ_wide;

  // Accumulate without wrap so the saturator sees the true running sum.
  always_comb begin
    integ_wide = ACC_W'(integ_q) + ACC_W'(err_d);
  end

  pid_sat #(
    .OUT_W(INT_W),
    .LO   (-longint'(INT_LIMIT)),
    .HI   (longint'(INT_LIMIT))
  ) u_int_sat (
    .value_i(integ_wide),
    .value_o(integ_d)
  );
`else
  // Free-running accumulator that wraps modulo 2^32.
  always_comb begin
    integ_d = integ_q + INT_W'(err_d);
  end
`endif

  pid_sat #(
    .OUT_W(16),
    .LO   (0),
    .HI   (65535)
  ) u_out_sat (
    .value_i(y_d),
    .value_o(out_d)
  );

  // Sequencer: one stage per cycle, start requests only honoured in IDLE.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q    <= IDLE;
      meas_q     <= '0;
      err_q      <= '0;
      prev_err_q <= '0;
      der_q      <= '0;
      integ_q    <= '0;
      p_q        <= '0;
      i_q        <= '0;
      d_q        <= '0;
      u_q        <= '0;
      data_out_q <= 16'(OUT_BIAS);
      done_q     <= 1'b0;
    end else begin
      done_q <= 1'b0;
      case (state_q)
        IDLE: begin
          if (pid_start) begin
            meas_q  <= data_in;
            state_q <= ERR;
          end
        end
        ERR: begin
          err_q      <= err_d;
          der_q      <= der_d;
          integ_q    <= integ_d;
          prev_err_q <= err_d;
          state_q    <= MUL;
        end
        MUL: begin
          p_q     <= p_d;
          i_q     <= i_d;
          d_q     <= d_d;
          state_q <= SUM;
        end
        SUM: begin
          u_q     <= u_d;
          state_q <= OUT;
        end
        OUT: begin
          data_out_q <= out_d;
          done_q     <= 1'b1;
          state_q    <= IDLE;
        end
        default: state_q <= IDLE;
      endcase
    end
  end

  assign data_out = data_out_q;
  assign pid_done = done_q;

endmodule

// File: tb/tb_pid_controller.sv
// Self-checking bench for pid_controller: directed runs, busy/reset corner
// cases and randomized measurements against an arithmetic reference model.
// Honours PID_INT_CLAMP_EN the same way the design does.
module tb_pid_controller;

  localparam longint SETPOINT  = 54321;
  localparam longint KP        = 16;
  localparam longint KI        = 2;
  localparam longint KD        = 8;
  localparam longint GAIN_DIV  = 16;
  localparam longint OUT_BIAS  = 32768;
  localparam longint INT_LIMIT = 1048576;

  logic        clk = 1'b0;
  logic        rst;
  logic        pidStart;
  logic [15:0] dataIn;
  logic [15:0] dataOut;
  logic        pidDone;

  int     checks    = 0;
  int     failures  = 0;
  longint modelInt  = 0;
  longint modelPrev = 0;

  pid_controller dut (
    .clk      (clk),
    .rst      (rst),
    .pid_start(pidStart),
    .data_in  (dataIn),
    .data_out (dataOut),
    .pid_done (pidDone)
  );

  // Free-running 100 MHz clock.
  always #5 clk = ~clk;

  // Counts one comparison and reports it when the values differ.
  task automatic checkOutput(input string tag, input longint observed, input longint expected);
    checks++;
    if (observed !== expected) begin
      failures++;
      $display("[TB] FAIL %s observed=%0d expected=%0d", tag, observed, expected);
    end
  endtask

  // Reference: one PID update in plain integer arithmetic, returns the control word.
  function automatic longint modelStep(input longint meas);
    longint e, d, s, u, y;
    e = SETPOINT - meas;
    d = e - modelPrev;
    modelPrev = e;
    modelInt = modelInt + e;
`ifdef PID_INT_CLAMP_EN
    if (modelInt > INT_LIMIT) modelInt = INT_LIMIT;
    else if (modelInt < -INT_LIMIT) modelInt = -INT_LIMIT;
`else
    modelInt = longint'(int'(modelInt));
`endif
    s = KP * e + KI * modelInt + KD * d;
    u = s / GAIN_DIV;
    if (s < 0 && (s % GAIN_DIV) != 0) u = u - 1;
    y = OUT_BIAS + u;
    if (y < 0) y = 0;
    else if (y > 65535) y = 65535;
    return y;
  endfunction

  function automatic void modelReset();
    modelInt  = 0;
    modelPrev = 0;
  endfunction

  // One complete run: pulse start, wait for done with a bound, check result.
  task automatic applyStimulus(input logic [15:0] meas, input string tag);
    longint expected;
    int     waitCycles;
    expected = modelStep(longint'(meas));
    dataIn   = meas;
    pidStart = 1'b1;
    @(posedge clk); #1;
    pidStart = 1'b0;
    dataIn   = 16'($urandom);
    waitCycles = 0;
    do begin
      @(posedge clk); #1;
      waitCycles++;
    end while (!pidDone && waitCycles < 10);
    checkOutput({tag, "_latency"}, waitCycles, 4);
    checkOutput({tag, "_data"}, dataOut, expected);
    @(posedge clk); #1;
    checkOutput({tag, "_done_pulse"}, pidDone, 0);
  endtask

  task automatic doReset();
    rst      = 1'b1;
    pidStart = 1'b0;
    repeat (2) @(posedge clk);
    #1;
    rst = 1'b0;
    modelReset();
  endtask

  initial begin
    longint      expected;
    longint      expectedSecond;
    int          doneCount;
    logic [15:0] meas;

    rst      = 1'b1;
    pidStart = 1'b0;
    dataIn   = '0;
    doReset();

    // Reset state and idle behaviour
    checkOutput("reset_data", dataOut, 32768);
    checkOutput("reset_done", pidDone, 0);
    repeat (5) begin
      @(posedge clk); #1;
      checkOutput("idle_done", pidDone, 0);
    end
    checkOutput("idle_data", dataOut, 32768);

    // Directed sequence with hand-derived results
    applyStimulus(16'd54321, "zero_err");
    checkOutput("zero_err_const", dataOut, 32768);
    applyStimulus(16'd55000, "neg_err");
    checkOutput("neg_err_const", dataOut, 31664);
    applyStimulus(16'd51000, "pos_err");
    checkOutput("pos_err_const", dataOut, 38419);

    // Saturation with a large persistent error
    for (int i = 0; i < 25; i++) applyStimulus(16'd0, "sat");
    checkOutput("sat_const", dataOut, 65535);

    // Start re-asserted while the FSM is in MUL must be ignored
    expected = modelStep(52000);
    dataIn   = 16'd52000;
    pidStart = 1'b1;
    @(posedge clk); #1;
    pidStart = 1'b0;
    @(posedge clk); #1;
    pidStart = 1'b1;
    @(posedge clk); #1;
    pidStart = 1'b0;
    @(posedge clk); #1;
    checkOutput("busy_early_done", pidDone, 0);
    @(posedge clk); #1;
    checkOutput("busy_done", pidDone, 1);
    checkOutput("busy_data", dataOut, expected);
    repeat (8) begin
      @(posedge clk); #1;
      checkOutput("busy_no_rerun", pidDone, 0);
    end

    // Reset while the run is in SUM aborts it
    dataIn   = 16'd40000;
    pidStart = 1'b1;
    @(posedge clk); #1;
    pidStart = 1'b0;
    @(posedge clk); #1;
    @(posedge clk); #1;
    rst = 1'b1;
    @(posedge clk); #1;
    rst = 1'b0;
    modelReset();
    checkOutput("abort_data", dataOut, 32768);
    repeat (6) begin
      @(posedge clk); #1;
      checkOutput("abort_no_done", pidDone, 0);
    end
    applyStimulus(16'd54321, "abort_zero");
    checkOutput("abort_zero_const", dataOut, 32768);
    applyStimulus(16'd55000, "abort_neg");
    checkOutput("abort_neg_const", dataOut, 31664);

    // Simultaneous reset and start: reset wins, start dropped
    dataIn   = 16'd0;
    pidStart = 1'b1;
    rst      = 1'b1;
    @(posedge clk); #1;
    rst      = 1'b0;
    pidStart = 1'b0;
    modelReset();
    repeat (6) begin
      @(posedge clk); #1;
      checkOutput("rst_start_no_done", pidDone, 0);
    end
    checkOutput("rst_start_data", dataOut, 32768);

    // Start held high: triggers again once the FSM is back in IDLE
    expected       = modelStep(50000);
    expectedSecond = modelStep(50000);
    dataIn    = 16'd50000;
    pidStart  = 1'b1;
    doneCount = 0;
    for (int c = 0; c < 16; c++) begin
      @(posedge clk); #1;
      if (c == 5) pidStart = 1'b0;
      if (pidDone) doneCount++;
      if (c == 4) checkOutput("held_first_data", dataOut, expected);
    end
    checkOutput("held_done_count", doneCount, 2);
    checkOutput("held_second_data", dataOut, expectedSecond);

    // Randomized measurements, mostly near the setpoint
    doReset();
    for (int i = 0; i < 40; i++) begin
      if (i % 4 == 0) meas = 16'($urandom);
      else meas = 16'($urandom_range(59000, 49000));
      applyStimulus(meas, "rand");
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
